// File: rtl/rvb_issue_if.sv
// rvb_issue_if: handshake bundle between the core, the bitmanip unit and the
// register-file writeback port for one rvb_issue instance.
//   req_*       core -> issue block, decoded op offer (valid/ready)
//   unit_din_*  issue block -> unit, op presentation (valid/ready)
//   unit_dout_* unit -> issue block, result return (valid/ready)
//   wb_*        issue block -> register file, {rd, data} writeback (valid/ready)
// Modports: slave = the issue block, master = its surroundings (core/unit/rf).
interface rvb_issue_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            req_insn3;
    logic            req_insn12;
    logic            req_insn13;
    logic [4:0]      req_rd;

    logic            unit_din_valid;
    logic            unit_din_ready;
    logic [XLEN-1:0] unit_din_rs1;
    logic [XLEN-1:0] unit_din_rs2;
    logic            unit_din_insn3;
    logic            unit_din_insn12;
    logic            unit_din_insn13;

    logic            unit_dout_valid;
    logic            unit_dout_ready;
    logic [XLEN-1:0] unit_dout_rd;

    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_insn3, req_insn12, req_insn13, req_rd,
        output req_ready,
        output unit_din_valid, unit_din_rs1, unit_din_rs2,
        output unit_din_insn3, unit_din_insn12, unit_din_insn13,
        input  unit_din_ready,
        input  unit_dout_valid, unit_dout_rd,
        output unit_dout_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_insn3, req_insn12, req_insn13, req_rd,
        input  req_ready,
        input  unit_din_valid, unit_din_rs1, unit_din_rs2,
        input  unit_din_insn3, unit_din_insn12, unit_din_insn13,
        output unit_din_ready,
        output unit_dout_valid, unit_dout_rd,
        input  unit_dout_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready
    );
endinterface

// File: rtl/rvb_issue.sv
// rvb_issue: in-order issue/writeback front-end for a multi-cycle bitmanip unit.
// Buffers decoded ops in a request FIFO, presents the FIFO head to the unit,
// remembers the destination register of every issued op in a tag FIFO, and
// pairs each returned result with its tag to drive the writeback port.
// Ports:
//   clock         positive-edge clock
//   resetn        asynchronous active-low reset
//   bus           rvb_issue_if.slave (req_*, unit_din_*, unit_dout_*, wb_*)
//   idle          request FIFO empty, nothing outstanding, writeback empty
//   err_spurious  sticky: unit returned a result with no op outstanding
module rvb_issue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int TAGS  = 2
) (
    input  logic       clock,
    input  logic       resetn,
    rvb_issue_if.slave bus,
    output logic       idle,
    output logic       err_spurious
);
    localparam int AW  = $clog2(DEPTH);
    localparam int TIW = (TAGS > 1) ? $clog2(TAGS) : 1;
    localparam int TCW = $clog2(TAGS + 1);

    localparam logic [AW:0]    PTR_ONE  = 1;
    localparam logic [TIW-1:0] TIDX_ONE = 1;
    localparam logic [TIW-1:0] TIDX_TOP = TIW'(TAGS - 1);
    localparam logic [TCW-1:0] TCNT_ONE = 1;
    localparam logic [TCW-1:0] TCNT_MAX = TCW'(TAGS);

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            insn3;
        logic            insn12;
        logic            insn13;
        logic [4:0]      rd;
    } op_t;

    op_t            fifo_mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [4:0]     tag_mem [TAGS];
    logic [TIW-1:0] tag_wr;
    logic [TIW-1:0] tag_rd;
    logic [TCW-1:0] tag_cnt;
    logic           wb_valid_q;
    logic [4:0]     wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic           err_q;

    op_t  op_in;
    op_t  head;
    logic [4:0] tag_head;
    logic fifo_empty, fifo_full, tag_empty, tag_full;
    logic push, issue, accept, wb_done;

    // Tag ring index step; TAGS need not fill the index range when TAGS == 1.
    function automatic logic [TIW-1:0] tag_next(input logic [TIW-1:0] p);
        return (p == TIDX_TOP) ? '0 : p + TIDX_ONE;
    endfunction

    assign op_in = {bus.req_rs1, bus.req_rs2, bus.req_insn3, bus.req_insn12,
                    bus.req_insn13, bus.req_rd};
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign tag_head = tag_mem[tag_rd];

    // Wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tag_empty  = (tag_cnt == '0);
    assign tag_full   = (tag_cnt == TCNT_MAX);

    assign bus.req_ready       = !fifo_full;
    assign bus.unit_din_valid  = !fifo_empty && !tag_full;
    assign bus.unit_din_rs1    = head.rs1;
    assign bus.unit_din_rs2    = head.rs2;
    assign bus.unit_din_insn3  = head.insn3;
    assign bus.unit_din_insn12 = head.insn12;
    assign bus.unit_din_insn13 = head.insn13;
    assign bus.unit_dout_ready = !tag_empty && (!wb_valid_q || bus.wb_ready);
    assign bus.wb_valid        = wb_valid_q;
    assign bus.wb_rd           = wb_rd_q;
    assign bus.wb_data         = wb_data_q;

    assign push    = bus.req_valid && !fifo_full;
    assign issue   = bus.unit_din_valid && bus.unit_din_ready;
    assign accept  = bus.unit_dout_valid && bus.unit_dout_ready;
    assign wb_done = wb_valid_q && bus.wb_ready;

    assign idle         = fifo_empty && tag_empty && !wb_valid_q;
    assign err_spurious = err_q;

    // Payload storage needs no reset: every read is qualified by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= op_in;
        end
        if (issue) begin
            tag_mem[tag_wr] <= head.rd;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_wr     <= '0;
            tag_rd     <= '0;
            tag_cnt    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                tag_wr <= tag_next(tag_wr);
            end
            if (accept) begin
                tag_rd <= tag_next(tag_rd);
            end
            case ({issue, accept})
                2'b10:   tag_cnt <= tag_cnt + TCNT_ONE;
                2'b01:   tag_cnt <= tag_cnt - TCNT_ONE;
                default: tag_cnt <= tag_cnt;
            endcase
            // Results for x0 are swallowed; a new load wins over a drain.
            if (accept && (tag_head != 5'd0)) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= tag_head;
                wb_data_q  <= bus.unit_dout_rd;
            end else if (wb_done) begin
                wb_valid_q <= 1'b0;
            end
            if (bus.unit_dout_valid && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rvb_issue.sv
module tb_rvb_issue;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int TAGS  = 2;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic idle;
    logic err_spurious;

    rvb_issue_if #(.XLEN(XLEN)) bus ();

    rvb_issue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGS(TAGS)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .bus          (bus),
        .idle         (idle),
        .err_spurious (err_spurious)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            i3;
        logic            i12;
        logic            i13;
        logic [4:0]      rd;
    } op_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    int total = 0;
    int bad   = 0;

    // Reference model: contents of the request buffer, outstanding tags,
    // results inside the unit, and the writeback register.
    op_t             m_fifo[$];
    logic [4:0]      m_tag[$];
    logic [XLEN-1:0] unit_q[$];
    op_t             req_src[$];
    wb_t             exp_q[$];
    logic            m_wbv;
    logic [4:0]      m_wbrd;
    logic [XLEN-1:0] m_wbdata;
    logic            m_err;

    int   p_req, p_din, p_dout, p_wb, p_x0, p_spur;
    bit   req_hold;
    op_t  cur;
    int   wb_count;
    logic seen_wb;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [XLEN-1:0] clmul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (b[i]) r = r ^ (a << i);
        end
        return r;
    endfunction

    function automatic bit rnd(int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic op_t mk_op(logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [4:0] rd);
        op_t o;
        o.rs1 = a; o.rs2 = b;
        o.i3 = 1'b0; o.i12 = 1'b1; o.i13 = 1'b0;
        o.rd = rd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.rs1 = {$urandom, $urandom};
        o.rs2 = {$urandom, $urandom};
        o.i3  = 1'($urandom_range(1));
        o.i12 = 1'($urandom_range(1));
        o.i13 = 1'($urandom_range(1));
        o.rd  = rnd(p_x0) ? 5'd0 : 5'($urandom_range(31, 1));
        return o;
    endfunction

    function automatic void model_reset();
        m_fifo.delete(); m_tag.delete(); unit_q.delete(); req_src.delete(); exp_q.delete();
        m_wbv = 1'b0; m_wbrd = '0; m_wbdata = '0; m_err = 1'b0;
        req_hold = 1'b0;
    endfunction

    task automatic drive_quiet();
        bus.req_valid = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        bus.req_insn3 = 1'b0; bus.req_insn12 = 1'b0; bus.req_insn13 = 1'b0; bus.req_rd = '0;
        bus.unit_din_ready = 1'b0; bus.unit_dout_valid = 1'b0; bus.unit_dout_rd = '0;
        bus.wb_ready = 1'b0;
    endtask

    function automatic void check_outputs();
        bit exp_din = (m_fifo.size() > 0) && (m_tag.size() < TAGS);
        chk("req_ready", bus.req_ready, 64'(m_fifo.size() < DEPTH));
        chk("din_valid", bus.unit_din_valid, 64'(exp_din));
        if (exp_din) begin
            chk("din_rs1", bus.unit_din_rs1, m_fifo[0].rs1);
            chk("din_rs2", bus.unit_din_rs2, m_fifo[0].rs2);
            chk("din_insn", {bus.unit_din_insn3, bus.unit_din_insn12, bus.unit_din_insn13},
                {m_fifo[0].i3, m_fifo[0].i12, m_fifo[0].i13});
        end
        chk("dout_ready", bus.unit_dout_ready, 64'((m_tag.size() > 0) && (!m_wbv || bus.wb_ready)));
        chk("wb_valid", bus.wb_valid, m_wbv);
        chk("wb_rd", bus.wb_rd, m_wbrd);
        chk("wb_data", bus.wb_data, m_wbdata);
        chk("idle", idle, 64'((m_fifo.size() == 0) && (m_tag.size() == 0) && !m_wbv));
        chk("err_spurious", err_spurious, m_err);
    endfunction

    // One clock cycle: drive at the falling edge, compare, advance the model.
    task automatic step();
        bit push, issue, acc, wbhs;
        op_t h;
        wb_t e;
        logic [4:0] t;
        logic [XLEN-1:0] d;
        @(negedge clock);
        if (!req_hold) begin
            if (req_src.size() > 0) begin
                cur = req_src.pop_front();
                bus.req_valid = 1'b1;
            end else if (rnd(p_req)) begin
                cur = rand_op();
                bus.req_valid = 1'b1;
            end else begin
                bus.req_valid = 1'b0;
            end
            bus.req_rs1 = cur.rs1; bus.req_rs2 = cur.rs2;
            bus.req_insn3 = cur.i3; bus.req_insn12 = cur.i12; bus.req_insn13 = cur.i13;
            bus.req_rd = cur.rd;
        end
        bus.unit_din_ready = rnd(p_din);
        if (unit_q.size() > 0) begin
            bus.unit_dout_valid = rnd(p_dout);
            bus.unit_dout_rd    = unit_q[0];
        end else begin
            bus.unit_dout_valid = rnd(p_spur);
            bus.unit_dout_rd    = {$urandom, $urandom};
        end
        bus.wb_ready = rnd(p_wb);
        #1;
        check_outputs();
        seen_wb = seen_wb | bus.wb_valid;

        push  = bus.req_valid && (m_fifo.size() < DEPTH);
        issue = (m_fifo.size() > 0) && (m_tag.size() < TAGS) && bus.unit_din_ready;
        acc   = bus.unit_dout_valid && (m_tag.size() > 0) && (!m_wbv || bus.wb_ready);
        wbhs  = m_wbv && bus.wb_ready;
        if (wbhs) begin
            wb_count++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_extra: writeback rd=%0d with nothing expected", bus.wb_rd);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rd", bus.wb_rd, e.rd);
                chk("sb_data", bus.wb_data, e.data);
            end
        end
        if (bus.unit_dout_valid && (m_tag.size() == 0)) m_err = 1'b1;
        if (acc) begin
            t = m_tag.pop_front();
            d = unit_q.pop_front();
            if (t != 5'd0) begin
                m_wbv = 1'b1; m_wbrd = t; m_wbdata = d;
            end else if (wbhs) begin
                m_wbv = 1'b0;
            end
        end else if (wbhs) begin
            m_wbv = 1'b0;
        end
        if (issue) begin
            h = m_fifo.pop_front();
            m_tag.push_back(h.rd);
            unit_q.push_back(clmul(h.rs1, h.rs2));
        end
        if (push) begin
            m_fifo.push_back(cur);
            if (cur.rd != 5'd0) begin
                e.rd = cur.rd; e.data = clmul(cur.rs1, cur.rs2);
                exp_q.push_back(e);
            end
        end
        req_hold = bus.req_valid && !push;
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_din_valid"}, bus.unit_din_valid, 0);
        chk({tag, "_dout_ready"}, bus.unit_dout_ready, 0);
        chk({tag, "_wb_valid"}, bus.wb_valid, 0);
        chk({tag, "_wb_rd"}, bus.wb_rd, 0);
        chk({tag, "_wb_data"}, bus.wb_data, 0);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_err"}, err_spurious, 0);
    endtask

    task automatic mid_reset();
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        drive_quiet();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic knobs(int rq, int di, int dq, int wb, int x0, int sp);
        p_req = rq; p_din = di; p_dout = dq; p_wb = wb; p_x0 = x0; p_spur = sp;
    endtask

    initial begin
        op_t o1;
        model_reset();
        drive_quiet();
        cur = '0;
        wb_count = 0;
        seen_wb = 1'b0;
        knobs(0, 100, 100, 100, 0, 0);
        repeat (2) @(negedge clock);
        #1;
        check_reset_values("rst");
        resetn = 1'b1;

        // Single CLMUL op: 3 clmul 5 = 0xF into x7.
        req_src.push_back(mk_op(64'd3, 64'd5, 5'd7));
        step(); chk("single_din_not_same_cycle", bus.unit_din_valid, 0);
        step(); chk("single_din_valid", bus.unit_din_valid, 1);
                chk("single_din_rs1", bus.unit_din_rs1, 3);
                chk("single_din_rs2", bus.unit_din_rs2, 5);
        step(); chk("single_dout_ready", bus.unit_dout_ready, 1);
        step(); chk("single_wb_valid", bus.wb_valid, 1);
                chk("single_wb_rd", bus.wb_rd, 7);
                chk("single_wb_data", bus.wb_data, 64'hF);
        step(); chk("single_idle", idle, 1);

        // Request FIFO backpressure with the unit stalled.
        knobs(0, 0, 100, 100, 0, 0);
        for (int i = 1; i <= 5; i++) req_src.push_back(mk_op({$urandom, $urandom}, {$urandom, $urandom}, 5'(i)));
        repeat (5) step();
        chk("bp_req_ready_full", bus.req_ready, 0);
        p_din = 100;
        wb_count = 0;
        repeat (20) step();
        chk("bp_wb_count", wb_count, 5);
        chk("bp_idle", idle, 1);

        // Tag limit with results held off.
        knobs(0, 100, 0, 100, 0, 0);
        for (int i = 0; i < 3; i++) req_src.push_back(mk_op({$urandom, $urandom}, {$urandom, $urandom}, 5'(9 + i)));
        repeat (4) step();
        chk("tag_full_din_valid", bus.unit_din_valid, 0);
        p_dout = 100;
        step(); chk("tag_release_din_valid", bus.unit_din_valid, 0);
        step(); chk("tag_third_issue", bus.unit_din_valid, 1);
        repeat (15) step();
        chk("tag_idle", idle, 1);

        // x0 destination is consumed without a writeback.
        knobs(0, 100, 100, 100, 0, 0);
        req_src.push_back(mk_op(64'd6, 64'd7, 5'd0));
        seen_wb = 1'b0;
        repeat (6) step();
        chk("x0_no_wb", seen_wb, 0);
        chk("x0_idle", idle, 1);

        // Writeback stall.
        knobs(0, 100, 100, 0, 0, 0);
        o1 = mk_op({$urandom, $urandom}, {$urandom, $urandom}, 5'd12);
        req_src.push_back(o1);
        req_src.push_back(mk_op({$urandom, $urandom}, {$urandom, $urandom}, 5'd13));
        req_src.push_back(mk_op({$urandom, $urandom}, {$urandom, $urandom}, 5'd14));
        repeat (8) step();
        chk("stall_dout_ready", bus.unit_dout_ready, 0);
        chk("stall_wb_valid", bus.wb_valid, 1);
        chk("stall_wb_rd", bus.wb_rd, 12);
        chk("stall_wb_data", bus.wb_data, clmul(o1.rs1, o1.rs2));
        repeat (3) step();
        chk("stall_wb_data_held", bus.wb_data, clmul(o1.rs1, o1.rs2));
        p_wb = 100;
        repeat (15) step();
        chk("stall_idle", idle, 1);

        // Spurious result with nothing outstanding.
        knobs(0, 100, 100, 100, 0, 100);
        step();
        p_spur = 0;
        step(); chk("spur_err_set", err_spurious, 1);
        repeat (5) step();
        chk("spur_err_sticky", err_spurious, 1);

        // Reset in the middle of traffic.
        knobs(80, 60, 60, 60, 10, 0);
        repeat (40) step();
        mid_reset();

        // Randomized segments.
        for (int seg = 0; seg < 20; seg++) begin
            knobs($urandom_range(100, 20), $urandom_range(100, 10), $urandom_range(100, 10),
                  $urandom_range(100, 10), $urandom_range(30), $urandom_range(5));
            repeat (200) step();
            if (seg == 10) mid_reset();
        end

        knobs(0, 100, 100, 100, 0, 0);
        repeat (30) step();
        chk("final_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
